// File: rtl/multiplier_pkg.sv
// Shared types and sizing helpers for the shift-add multiplier sequencer.
package multiplier_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} seq_state_t;

  // Number of R-bit steps needed to retire an N-bit operand.
  function automatic int step_count(input int n, input int r);
    return n / r;
  endfunction

  // Counter width: max(1, clog2(s)).
  function automatic int ctr_width(input int s);
    return (s <= 2) ? 1 : $clog2(s);
  endfunction

endpackage

// File: rtl/multiplier_step_counter.sv
// Remaining-step down-counter; load wins over decrement and it never wraps below zero.
module multiplier_step_counter
  import multiplier_pkg::*;
#(
  parameter int C = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [C-1:0] load_value,
  input  logic         decrement,
  output logic [C-1:0] count,
  output logic         is_zero
);

  logic [C-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load)
      count_d = load_value;
    else if (decrement && (count_q != '0))
      count_d = count_q - C'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count   = count_q;
  assign is_zero = (count_q == '0);

endmodule

// File: rtl/multiplier_sequencer.sv
// Control FSM for the iterative shift-add multiplier: start handshake, one load
// cycle, len+1 step cycles, then a held result handshake. Abort returns to IDLE.
module multiplier_sequencer
  import multiplier_pkg::*;
#(
  parameter  int N = 8,
  parameter  int R = 1,
  localparam int S = step_count(N, R),
  localparam int C = ctr_width(S)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [C-1:0] len,
  input  logic         abort,
  output logic         load_en,
  output logic         step_en,
  output logic         last_step,
  output logic [C-1:0] count,
  output logic         busy,
  output logic         result_valid,
  input  logic         result_ready
);

  if ((N % R) != 0) begin : g_bad_radix
    $error("multiplier_sequencer: N must be a multiple of R");
  end

  localparam logic [C-1:0] LEN_MAX = C'(S - 1);

  seq_state_t   state_q, state_d;
  logic [C-1:0] len_q, len_d;
  logic         ctr_load, ctr_dec, ctr_zero;
  logic [C-1:0] ctr_value;

  multiplier_step_counter #(.C(C)) u_ctr (
    .clock      (clock),
    .reset      (reset),
    .load       (ctr_load),
    .load_value (ctr_value),
    .decrement  (ctr_dec),
    .count      (count),
    .is_zero    (ctr_zero)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    ctr_load     = 1'b0;
    ctr_value    = '0;
    ctr_dec      = 1'b0;
    start_ready  = 1'b0;
    load_en      = 1'b0;
    step_en      = 1'b0;
    last_step    = 1'b0;
    busy         = 1'b0;
    result_valid = 1'b0;
    case (state_q)
      IDLE: begin
        start_ready = ~abort;
        if (start_valid && !abort) begin
          // Lengths beyond the operand width saturate (only reachable when S isn't a power of two).
          len_d   = (len > LEN_MAX) ? LEN_MAX : len;
          state_d = LOAD;
        end
      end
      LOAD: begin
        load_en  = 1'b1;
        busy     = 1'b1;
        ctr_load = 1'b1;
        if (abort) begin
          state_d = IDLE;
        end else begin
          ctr_value = len_q;
          state_d   = RUN;
        end
      end
      RUN: begin
        step_en   = 1'b1;
        busy      = 1'b1;
        last_step = ctr_zero;
        if (abort) begin
          ctr_load = 1'b1;
          state_d  = IDLE;
        end else if (ctr_zero) begin
          state_d = DONE;
        end else begin
          ctr_dec = 1'b1;
        end
      end
      DONE: begin
        result_valid = 1'b1;
        busy         = 1'b1;
        if (abort) begin
          ctr_load = 1'b1;
          state_d  = IDLE;
        end else if (result_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  a_excl: assert property (@(posedge clock) disable iff (reset)
    $onehot0({load_en, step_en, result_valid}));
  a_last: assert property (@(posedge clock) disable iff (reset)
    last_step |-> step_en);

endmodule

// File: tb/tb_multiplier_sequencer.sv
// Bench for multiplier_sequencer: three configurations (8/1, 8/2, 12/1) checked
// against a per-cycle schedule derived from the start-to-result timing rules.
module tb_multiplier_sequencer;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic       sv [3];
  logic       ab [3];
  logic       rr [3];
  logic [3:0] lenv [3];
  logic       sr [3], le [3], se [3], ls [3], bz [3], rv [3];
  logic [2:0] cnt0;
  logic [1:0] cnt1;
  logic [3:0] cnt2;
  int         cntv [3];

  always_comb begin
    cntv[0] = int'(cnt0);
    cntv[1] = int'(cnt1);
    cntv[2] = int'(cnt2);
  end

  multiplier_sequencer #(.N(8), .R(1)) dut0 (
    .clock(clock), .reset(reset), .start_valid(sv[0]), .start_ready(sr[0]),
    .len(lenv[0][2:0]), .abort(ab[0]), .load_en(le[0]), .step_en(se[0]),
    .last_step(ls[0]), .count(cnt0), .busy(bz[0]), .result_valid(rv[0]),
    .result_ready(rr[0]));

  multiplier_sequencer #(.N(8), .R(2)) dut1 (
    .clock(clock), .reset(reset), .start_valid(sv[1]), .start_ready(sr[1]),
    .len(lenv[1][1:0]), .abort(ab[1]), .load_en(le[1]), .step_en(se[1]),
    .last_step(ls[1]), .count(cnt1), .busy(bz[1]), .result_valid(rv[1]),
    .result_ready(rr[1]));

  multiplier_sequencer #(.N(12), .R(1)) dut2 (
    .clock(clock), .reset(reset), .start_valid(sv[2]), .start_ready(sr[2]),
    .len(lenv[2]), .abort(ab[2]), .load_en(le[2]), .step_en(se[2]),
    .last_step(ls[2]), .count(cnt2), .busy(bz[2]), .result_valid(rv[2]),
    .result_ready(rr[2]));

  int total = 0;
  int bad   = 0;
  int smax  [3] = '{8, 4, 12};
  int lmax  [3] = '{7, 3, 15};

  typedef struct {
    int d;
    int len;
    int rdly;
    int exp_steps;
  } vec_t;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // One full operation from IDLE; expectations come from the timing rules:
  // handshake at t, load at t+1, steps t+2..t+2+L, result from t+3+L.
  task automatic run_op(input int d, input int len, input int rdly, output int nsteps);
    int L;
    L = (len > smax[d] - 1) ? smax[d] - 1 : len;
    nsteps = 0;
    sv[d] = 1'b1; lenv[d] = 4'(len);
    #1 chk("start_ready_idle", int'(sr[d]), 1);
    tick();
    sv[d] = 1'b0; lenv[d] = '0;
    #1;
    chk("load_en", int'(le[d]), 1);
    chk("load_step", int'(se[d]), 0);
    chk("load_busy", int'(bz[d]), 1);
    chk("load_start_ready", int'(sr[d]), 0);
    tick();
    for (int k = 0; k <= L; k++) begin
      #1;
      if (se[d]) nsteps++;
      chk("run_step", int'(se[d]), 1);
      chk("run_last", int'(ls[d]), (k == L) ? 1 : 0);
      chk("run_count", cntv[d], L - k);
      chk("run_rv", int'(rv[d]), 0);
      tick();
    end
    for (int j = 0; j < rdly; j++) begin
      sv[d] = 1'b1;
      #1;
      chk("done_rv_hold", int'(rv[d]), 1);
      chk("done_start_ready", int'(sr[d]), 0);
      chk("done_step", int'(se[d]), 0);
      chk("done_count", cntv[d], 0);
      tick();
    end
    sv[d] = 1'b0; rr[d] = 1'b1;
    #1 chk("done_rv", int'(rv[d]), 1);
    tick();
    rr[d] = 1'b0;
    #1;
    chk("idle_rv", int'(rv[d]), 0);
    chk("idle_busy", int'(bz[d]), 0);
    chk("idle_start_ready", int'(sr[d]), 1);
    chk("idle_load", int'(le[d]), 0);
  endtask

  initial begin
    vec_t vecs [9];
    int   n;
    vecs[0] = '{0, 7, 0, 8};
    vecs[1] = '{0, 0, 1, 1};
    vecs[2] = '{0, 3, 3, 4};
    vecs[3] = '{0, 5, 2, 6};
    vecs[4] = '{1, 0, 0, 1};
    vecs[5] = '{1, 3, 1, 4};
    vecs[6] = '{2, 15, 0, 12};
    vecs[7] = '{2, 11, 1, 12};
    vecs[8] = '{2, 4, 0, 5};

    for (int i = 0; i < 3; i++) begin
      sv[i] = 1'b0; ab[i] = 1'b0; rr[i] = 1'b0; lenv[i] = '0;
    end
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_start_ready", int'(sr[i]), 1);
      chk("rst_busy", int'(bz[i]), 0);
      chk("rst_load", int'(le[i]), 0);
      chk("rst_step", int'(se[i]), 0);
      chk("rst_rv", int'(rv[i]), 0);
      chk("rst_count", cntv[i], 0);
    end
    tick();

    foreach (vecs[i]) begin
      run_op(vecs[i].d, vecs[i].len, vecs[i].rdly, n);
      chk("vec_steps", n, vecs[i].exp_steps);
      tick();
    end

    for (int i = 0; i < 15; i++) begin
      int d, l, r, e;
      d = int'($urandom_range(0, 2));
      l = int'($urandom_range(0, lmax[d]));
      r = int'($urandom_range(0, 3));
      e = ((l > smax[d] - 1) ? smax[d] - 1 : l) + 1;
      run_op(d, l, r, n);
      chk("rand_steps", n, e);
      if ($urandom_range(0, 1) == 1) tick();
    end

    // Abort on the third RUN cycle, then an immediate new start.
    sv[0] = 1'b1; lenv[0] = 4'd7;
    tick();
    sv[0] = 1'b0;
    tick(); tick(); tick();
    ab[0] = 1'b1;
    #1 chk("abort_run3_step", int'(se[0]), 1);
    tick();
    ab[0] = 1'b0;
    #1;
    chk("abort_step", int'(se[0]), 0);
    chk("abort_busy", int'(bz[0]), 0);
    chk("abort_count", cntv[0], 0);
    chk("abort_rv", int'(rv[0]), 0);
    chk("abort_start_ready", int'(sr[0]), 1);
    run_op(0, 2, 0, n);
    chk("after_abort_steps", n, 3);
    tick();

    // Abort in LOAD.
    sv[0] = 1'b1; lenv[0] = 4'd5;
    tick();
    sv[0] = 1'b0; ab[0] = 1'b1;
    #1 chk("abort_load_le", int'(le[0]), 1);
    tick();
    ab[0] = 1'b0;
    #1;
    chk("abort_load_busy", int'(bz[0]), 0);
    chk("abort_load_step", int'(se[0]), 0);
    chk("abort_load_count", cntv[0], 0);

    // Abort in IDLE blocks the start.
    ab[0] = 1'b1; sv[0] = 1'b1;
    #1 chk("idle_abort_sr", int'(sr[0]), 0);
    tick();
    ab[0] = 1'b0; sv[0] = 1'b0;
    #1;
    chk("idle_abort_load", int'(le[0]), 0);
    chk("idle_abort_busy", int'(bz[0]), 0);

    // Reset pulse mid-RUN while start_valid is held.
    sv[0] = 1'b1; lenv[0] = 4'd7;
    tick();
    sv[0] = 1'b0;
    tick(); tick();
    reset = 1'b1; sv[0] = 1'b1;
    tick();
    #1;
    chk("rst_mid_busy", int'(bz[0]), 0);
    chk("rst_mid_step", int'(se[0]), 0);
    tick();
    #1 chk("rst_mid_load", int'(le[0]), 0);
    reset = 1'b0; sv[0] = 1'b0;
    tick();
    #1;
    chk("rst_after_sr", int'(sr[0]), 1);
    chk("rst_after_busy", int'(bz[0]), 0);
    chk("rst_after_count", cntv[0], 0);
    chk("rst_after_load", int'(le[0]), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
